// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit.
//   ls_size_e : access-size codes driven by the controller on ls_size
//   state_e   : access FSM states
//   isLegal   : size/alignment legality check for a request
package dmem_access_unit_pkg;

  // Access-size codes, as mapped from the instruction type by the controller.
  typedef enum logic [2:0] {
    LS_W  = 3'd0,
    LS_H  = 3'd1,
    LS_HU = 3'd2,
    LS_B  = 3'd3,
    LS_BU = 3'd4
  } ls_size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RMW     = 3'd2,
    RESP    = 3'd3,
    ERR     = 3'd4
  } state_e;

  // Words must be 4-byte aligned, halves 2-byte aligned, bytes anywhere.
  // Any size code outside the defined set is illegal.
  function automatic logic isLegal(input logic [2:0] size, input logic [1:0] offset);
    logic legal;
    case (size)
      LS_W:        legal = (offset == 2'b00);
      LS_H, LS_HU: legal = ~offset[0];
      LS_B, LS_BU: legal = 1'b1;
      default:     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Controller <-> access unit handshake.
//   M_R/M_W   : read / write request strobes (controller drives)
//   ls_size   : access size code
//   addr      : byte address
//   wdata     : store data
//   rdata     : extended load result (unit drives)
//   done      : one-cycle completion pulse
//   busy      : unit is working on a request
//   addr_err  : one-cycle misalignment / illegal-request pulse
interface dmem_access_unit_if;
  logic        M_R;
  logic        M_W;
  logic [2:0]  ls_size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        addr_err;

  modport master (
    output M_R, M_W, ls_size, addr, wdata,
    input  rdata, done, busy, addr_err
  );

  modport slave (
    input  M_R, M_W, ls_size, addr, wdata,
    output rdata, done, busy, addr_err
  );
endinterface

// File: rtl/dmem_lane_mux.sv
// Combinational byte/half lane logic for the access unit.
//   i_size   : access size code
//   i_offset : byte offset within the word
//   i_rword  : word read from RAM
//   i_wdata  : store data (low byte/half used for SB/SH)
//   o_load   : selected lane, sign- or zero-extended
//   o_merged : RAM word with the store lane replaced (read-modify-write)
module dmem_lane_mux
  import dmem_access_unit_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection is little-endian: byte k sits at bits [8k+7:8k].
  always_comb begin
    w_byte = i_rword[7:0];
    case (i_offset)
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = i_rword[7:0];
    endcase
    w_half = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
  end

  // Extension for loads and lane replacement for narrow stores.
  always_comb begin
    o_load   = i_rword;
    o_merged = i_wdata;
    case (i_size)
      LS_H:  o_load = {{16{w_half[15]}}, w_half};
      LS_HU: o_load = {16'h0000, w_half};
      LS_B:  o_load = {{24{w_byte[7]}}, w_byte};
      LS_BU: o_load = {24'h000000, w_byte};
      default: o_load = i_rword;
    endcase
    case (i_size)
      LS_H, LS_HU:
        o_merged = i_offset[1] ? {i_wdata[15:0], i_rword[15:0]}
                               : {i_rword[31:16], i_wdata[15:0]};
      LS_B, LS_BU:
        case (i_offset)
          2'd1:    o_merged = {i_rword[31:16], i_wdata[7:0], i_rword[7:0]};
          2'd2:    o_merged = {i_rword[31:24], i_wdata[7:0], i_rword[15:0]};
          2'd3:    o_merged = {i_wdata[7:0], i_rword[23:0]};
          default: o_merged = {i_rword[31:8], i_wdata[7:0]};
        endcase
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-side responder to the controller's M_R/M_W strobes. Executes
// word/half/byte loads and stores on a word-wide synchronous RAM without
// byte enables; narrow stores use read-modify-write.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : controller handshake (slave side)
//   o_ram_en     : RAM enable
//   o_ram_we     : RAM full-word write enable
//   o_ram_addr   : RAM word address
//   o_ram_wdata  : RAM write word
//   i_ram_rdata  : RAM read word, valid the cycle after a read enable
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h10010000
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_access_unit_if.slave    bus,
  output logic                 o_ram_en,
  output logic                 o_ram_we,
  output logic [ADDR_W-1:0]    o_ram_addr,
  output logic [31:0]          o_ram_wdata,
  input  logic [31:0]          i_ram_rdata
);

  state_e              r_state;
  state_e              w_nextState;
  logic [31:0]         r_rdata;
  logic [ADDR_W-1:0]   r_wordAddr;
  logic [1:0]          r_lane;
  logic [2:0]          r_size;
  logic [31:0]         r_wdata;

  logic [31:0]         w_offsetFull;
  logic [ADDR_W+1:0]   w_offset;
  logic                w_unusedHigh;
  logic                w_accept;
  logic                w_ramEn;
  logic                w_ramWe;
  logic [ADDR_W-1:0]   w_ramAddr;
  logic [31:0]         w_ramWdata;
  logic [31:0]         w_load;
  logic [31:0]         w_merged;

  // The offset from the RAM base wraps modulo the RAM size; the high bits
  // are intentionally discarded.
  assign w_offsetFull = bus.addr - BASE_ADDR;
  assign w_offset     = w_offsetFull[ADDR_W+1:0];
  assign w_unusedHigh = ^w_offsetFull[31:ADDR_W+2];

  dmem_lane_mux u_laneMux (
    .i_size   (r_size),
    .i_offset (r_lane),
    .i_rword  (i_ram_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // State register, request latches and the load result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rdata    <= '0;
      r_wordAddr <= '0;
      r_lane     <= '0;
      r_size     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_wordAddr <= w_offset[ADDR_W+1:2];
        r_lane     <= w_offset[1:0];
        r_size     <= bus.ls_size;
        r_wdata    <= bus.wdata;
      end
      if (r_state == RD_WAIT) begin
        r_rdata <= w_load;
      end
    end
  end

  // Next state and RAM strobes. The first RAM access is issued in the same
  // cycle the request is seen in IDLE, addressed straight from the bus; the
  // RMW write-back reuses the latched word address.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_ramEn     = 1'b0;
    w_ramWe     = 1'b0;
    w_ramAddr   = '0;
    w_ramWdata  = '0;
    case (r_state)
      IDLE: begin
        if (bus.M_R || bus.M_W) begin
          if ((bus.M_R && bus.M_W) || !isLegal(bus.ls_size, w_offset[1:0])) begin
            w_nextState = ERR;
          end else begin
            w_accept  = 1'b1;
            w_ramEn   = 1'b1;
            w_ramAddr = w_offset[ADDR_W+1:2];
            if (bus.M_R) begin
              w_nextState = RD_WAIT;
            end else if (bus.ls_size == LS_W) begin
              w_ramWe     = 1'b1;
              w_ramWdata  = bus.wdata;
              w_nextState = RESP;
            end else begin
              w_nextState = RMW;
            end
          end
        end
      end
      RD_WAIT: w_nextState = RESP;
      RMW: begin
        w_ramEn     = 1'b1;
        w_ramWe     = 1'b1;
        w_ramAddr   = r_wordAddr;
        w_ramWdata  = w_merged;
        w_nextState = RESP;
      end
      RESP:    w_nextState = IDLE;
      ERR:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is high so an access in flight
  // can never commit a write once reset has been asserted.
  assign o_ram_en     = w_ramEn & ~rst;
  assign o_ram_we     = w_ramWe & ~rst;
  assign o_ram_addr   = rst ? '0 : w_ramAddr;
  assign o_ram_wdata  = rst ? '0 : w_ramWdata;
  assign bus.rdata    = r_rdata;
  assign bus.done     = ~rst & ((r_state == RESP) || (r_state == ERR));
  assign bus.busy     = ~rst & (r_state != IDLE);
  assign bus.addr_err = ~rst & (r_state == ERR);

endmodule
